rename_register_file: RTL and testbench
=======================================

// Module: rename_register_file
// PURPOSE
//  Architectural register file with per-register rename tags.
//  - Next generation of the single-commit register file: XLEN, depth, ROB tag width and read-port count are all parameters.
//  - Adds commit-to-read bypass and a global flush on mispredict.
//  - Sits between the ROB (launch/commit), the issue stage and the reservation stations (operand lookup).
// PARAMETERS
//  XLEN          32  data width
//  NUM_REGS      32  architectural registers; reg 0 is hardwired to zero
//  REG_ID_W       5  register index width, clog2(NUM_REGS)
//  ROB_TAG_W      5  ROB entry id width
//  NUM_RD_PORTS   2  operand lookup ports
// PORTS
//  clk_in          in   1                     system clock
//  rst_in          in   1                     asynchronous reset, active-low
//  rdy_in          in   1                     low = hold all state; reads stay valid
//  flush_in        in   1                     mispredict: drop all rename tags
//  launch_valid    in   1                     ROB allocates an entry with destination launch_reg_id
//  launch_rob_id   in   ROB_TAG_W             tag of the new producer
//  launch_reg_id   in   REG_ID_W              destination register
//  commit_valid    in   1                     ROB retires an entry
//  commit_rob_id   in   ROB_TAG_W             retiring tag
//  commit_reg_id   in   REG_ID_W              destination of the retiring entry
//  commit_value    in   XLEN                  retired result
//  rd_reg_id       in   NUM_RD_PORTS*REG_ID_W  packed lookup indices, port p = slice p
//  rd_has_dep      out  NUM_RD_PORTS          1 = operand still pending in the ROB
//  rd_dep_rob_id   out  NUM_RD_PORTS*ROB_TAG_W producer tag; 0 when rd_has_dep=0
//  rd_value        out  NUM_RD_PORTS*XLEN     operand value; 0 when rd_has_dep=1
// BEHAVIOUR
//  State: value[NUM_REGS], busy[NUM_REGS], tag[NUM_REGS].
//  Reset (rst_in=0, async):
//  - all value, busy and tag entries cleared.
//  - outputs therefore read has_dep=0, dep=0, value=0 for every port.
//  Updates: on posedge clk_in, only when rdy_in=1; visible to reads the next cycle.
//  Commit (commit_valid, reg!=0):
//  - value[reg] <= commit_value unconditionally.
//  - busy[reg] <= 0 only if busy[reg] && tag[reg]==commit_rob_id; a newer producer keeps the register busy.
//  Launch (launch_valid, reg!=0, !flush_in): busy[reg] <= 1, tag[reg] <= launch_rob_id.
//  Launch and commit to the same reg in the same cycle:
//  - value is written.
//  - busy stays 1 with the new launch tag (launch wins over commit tag clear).
//  flush_in:
//  - all busy bits cleared and tags zeroed.
//  - a commit in the same cycle still writes its value.
//  - a launch in the same cycle is dropped.
//  Register 0: launch and commit to it are ignored; reads always give value 0, no dependency.
//  Reads are combinational, zero latency, per port p:
//  - busy && commit_valid && commit_rob_id==tag && commit_reg_id==id: has_dep=0, value=commit_value (bypass).
//  - busy otherwise: has_dep=1, dep=tag, value=0.
//  - not busy: has_dep=0, dep=0, value=value[id].
//  - Reads never see a same-cycle launch, so an instruction whose rd equals its rs reads the old mapping.
//  - Reads ignore rdy_in and flush_in.
// STRUCTURE
//  cpu_pkg holds XLEN, REG_ID_W, ROB_TAG_W and NUM_REGS as shared constants, used alongside the ROB and RS.
//  Sub-module rf_read_port: one combinational lookup with bypass, instantiated NUM_RD_PORTS times in a generate loop.
//  Top level holds the storage arrays and the launch/commit/flush update logic.
// TESTING
//  1. Reset with rst_in low mid-cycle, after busy regs exist -> all ports read dep=0, value=0 immediately, without a clock edge.
//  2. launch r5 tag 3; next cycle read r5 -> has_dep=1, dep=3.
//     Then commit tag 3, value 0xDEAD_BEEF -> same-cycle read returns has_dep=0, value 0xDEAD_BEEF.
//     Next cycle the stored value is returned.
//  3. launch r7 tag 1, then launch r7 tag 4, then commit tag 1 value 9 -> value[7]=9, r7 still dep=4.
//  4. Same-cycle launch r2 tag 6 and commit r2 tag 6 (previous) -> r2 busy with tag 6, value updated.
//  5. launch r3/r4, then flush_in with launch r8 in the same cycle -> r3, r4 and r8 all read has_dep=0.
//  6. launch/commit to r0, and rdy_in=0 with a launch on r9 -> r0 reads 0 with no dependency; r9 is unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core constants used by the register file, ROB and reservation stations.
// Widths here size the rename tags and operand buses.
package cpu_pkg;

  localparam int XLEN         = 32;
  localparam int NUM_REGS     = 32;
  localparam int REG_ID_W     = 5;
  localparam int ROB_TAG_W    = 5;
  localparam int NUM_RD_PORTS = 2;

  typedef struct packed {
    logic                 has_dep;
    logic [ROB_TAG_W-1:0] dep;
    logic [XLEN-1:0]      value;
  } rd_rsp_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational operand lookup with commit-to-read bypass.
// Register 0 always reads as a ready zero.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int P_XLEN      = XLEN,
  parameter int P_NUM_REGS  = NUM_REGS,
  parameter int P_REG_ID_W  = REG_ID_W,
  parameter int P_ROB_TAG_W = ROB_TAG_W
) (
  input  logic [P_REG_ID_W-1:0]  reg_id,
  input  logic [P_NUM_REGS-1:0]  busy,
  input  logic [P_ROB_TAG_W-1:0] tag [P_NUM_REGS],
  input  logic [P_XLEN-1:0]      value [P_NUM_REGS],
  input  logic                   commit_valid,
  input  logic [P_ROB_TAG_W-1:0] commit_rob_id,
  input  logic [P_REG_ID_W-1:0]  commit_reg_id,
  input  logic [P_XLEN-1:0]      commit_value,
  output logic                   has_dep,
  output logic [P_ROB_TAG_W-1:0] dep,
  output logic [P_XLEN-1:0]      rd_value
);

  logic                   is_zero;
  logic                   hit_busy;
  logic [P_ROB_TAG_W-1:0] hit_tag;
  logic                   bypass;

  assign is_zero  = (reg_id == '0);
  assign hit_busy = busy[reg_id] && !is_zero;
  assign hit_tag  = tag[reg_id];

  // The retiring producer's result is forwarded before it lands in storage.
  assign bypass = commit_valid
               && (commit_rob_id == hit_tag)
               && (commit_reg_id == reg_id);

  always_comb begin
    has_dep  = 1'b0;
    dep      = '0;
    rd_value = '0;
    unique case (1'b1)
      hit_busy && bypass: begin
        rd_value = commit_value;
      end
      hit_busy && !bypass: begin
        has_dep = 1'b1;
        dep     = hit_tag;
      end
      !hit_busy && !is_zero: begin
        rd_value = value[reg_id];
      end
      default: begin
        rd_value = '0;
      end
    endcase
  end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags,
// commit bypass on reads and a global flush of pending mappings.
module rename_register_file
  import cpu_pkg::*;
#(
  parameter int P_XLEN         = XLEN,
  parameter int P_NUM_REGS     = NUM_REGS,
  parameter int P_REG_ID_W     = REG_ID_W,
  parameter int P_ROB_TAG_W    = ROB_TAG_W,
  parameter int P_NUM_RD_PORTS = NUM_RD_PORTS
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                rdy_in,
  input  logic                                flush_in,
  input  logic                                launch_valid,
  input  logic [P_ROB_TAG_W-1:0]              launch_rob_id,
  input  logic [P_REG_ID_W-1:0]               launch_reg_id,
  input  logic                                commit_valid,
  input  logic [P_ROB_TAG_W-1:0]              commit_rob_id,
  input  logic [P_REG_ID_W-1:0]               commit_reg_id,
  input  logic [P_XLEN-1:0]                   commit_value,
  input  logic [P_NUM_RD_PORTS*P_REG_ID_W-1:0]  rd_reg_id,
  output logic [P_NUM_RD_PORTS-1:0]             rd_has_dep,
  output logic [P_NUM_RD_PORTS*P_ROB_TAG_W-1:0] rd_dep_rob_id,
  output logic [P_NUM_RD_PORTS*P_XLEN-1:0]      rd_value
);

  logic [P_XLEN-1:0]      value [P_NUM_REGS];
  logic [P_ROB_TAG_W-1:0] tag   [P_NUM_REGS];
  logic [P_NUM_REGS-1:0]  busy;

  logic commit_en;
  logic commit_clr;
  logic launch_en;

  assign commit_en  = commit_valid && (commit_reg_id != '0);
  assign commit_clr = commit_en
                   && busy[commit_reg_id]
                   && (tag[commit_reg_id] == commit_rob_id);
  assign launch_en  = launch_valid && (launch_reg_id != '0) && !flush_in;

  // Later assignments win: launch overrides a same-cycle tag clear,
  // and flush overrides both busy updates.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy <= '0;
      for (int i = 0; i < P_NUM_REGS; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (commit_en) begin
        value[commit_reg_id] <= commit_value;
      end
      if (commit_clr) begin
        busy[commit_reg_id] <= 1'b0;
      end
      if (flush_in) begin
        busy <= '0;
        for (int i = 0; i < P_NUM_REGS; i++) begin
          tag[i] <= '0;
        end
      end else if (launch_en) begin
        busy[launch_reg_id] <= 1'b1;
        tag[launch_reg_id]  <= launch_rob_id;
      end
    end
  end

  for (genvar p = 0; p < P_NUM_RD_PORTS; p++) begin : g_rd
    rf_read_port #(
      .P_XLEN      (P_XLEN),
      .P_NUM_REGS  (P_NUM_REGS),
      .P_REG_ID_W  (P_REG_ID_W),
      .P_ROB_TAG_W (P_ROB_TAG_W)
    ) u_port (
      .reg_id        (rd_reg_id[p*P_REG_ID_W +: P_REG_ID_W]),
      .busy          (busy),
      .tag           (tag),
      .value         (value),
      .commit_valid  (commit_valid),
      .commit_rob_id (commit_rob_id),
      .commit_reg_id (commit_reg_id),
      .commit_value  (commit_value),
      .has_dep       (rd_has_dep[p]),
      .dep           (rd_dep_rob_id[p*P_ROB_TAG_W +: P_ROB_TAG_W]),
      .rd_value      (rd_value[p*P_XLEN +: P_XLEN])
    );
  end

endmodule

// File: tb/tb_rename_register_file.sv
// Directed bench for rename_register_file: launch, commit, bypass,
// flush, register 0, hold and asynchronous reset.
module tb_rename_register_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        launch_valid;
  logic [4:0]  launch_rob_id;
  logic [4:0]  launch_reg_id;
  logic        commit_valid;
  logic [4:0]  commit_rob_id;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_value;
  logic [9:0]  rd_reg_id;
  logic [1:0]  rd_has_dep;
  logic [9:0]  rd_dep_rob_id;
  logic [63:0] rd_value;

  int passes = 0;
  int total  = 0;

  rename_register_file dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_in      (flush_in),
    .launch_valid  (launch_valid),
    .launch_rob_id (launch_rob_id),
    .launch_reg_id (launch_reg_id),
    .commit_valid  (commit_valid),
    .commit_rob_id (commit_rob_id),
    .commit_reg_id (commit_reg_id),
    .commit_value  (commit_value),
    .rd_reg_id     (rd_reg_id),
    .rd_has_dep    (rd_has_dep),
    .rd_dep_rob_id (rd_dep_rob_id),
    .rd_value      (rd_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  // Check one read port: has_dep, dep tag and value.
  task automatic port(input string name, input int p, input logic hd,
                      input logic [4:0] dp, input logic [31:0] v);
    chk({name, ".has_dep"}, 32'(rd_has_dep[p]), 32'(hd));
    chk({name, ".dep"}, 32'(rd_dep_rob_id[p*5 +: 5]), 32'(dp));
    chk({name, ".value"}, rd_value[p*32 +: 32], v);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_reg_id = {b, a};
    #1;
  endtask

  task automatic launch(input logic [4:0] r, input logic [4:0] t);
    launch_valid  = 1'b1;
    launch_reg_id = r;
    launch_rob_id = t;
  endtask

  task automatic commit(input logic [4:0] r, input logic [4:0] t,
                        input logic [31:0] v);
    commit_valid  = 1'b1;
    commit_reg_id = r;
    commit_rob_id = t;
    commit_value  = v;
  endtask

  task automatic idle();
    launch_valid = 1'b0;
    commit_valid = 1'b0;
    flush_in     = 1'b0;
  endtask

  initial begin
    rst_in        = 1'b0;
    rdy_in        = 1'b1;
    flush_in      = 1'b0;
    launch_valid  = 1'b0;
    launch_rob_id = '0;
    launch_reg_id = '0;
    commit_valid  = 1'b0;
    commit_rob_id = '0;
    commit_reg_id = '0;
    commit_value  = '0;
    rd_reg_id     = '0;
    #12;
    rst_in = 1'b1;
    tick();

    rd(5'd5, 5'd31);
    port("rst_p0", 0, 1'b0, 5'd0, 32'h0);
    port("rst_p1", 1, 1'b0, 5'd0, 32'h0);

    // launch r5 tag 3, then commit with bypass
    launch(5'd5, 5'd3);
    tick();
    idle();
    rd(5'd5, 5'd7);
    port("l5", 0, 1'b1, 5'd3, 32'h0);
    port("r7_free", 1, 1'b0, 5'd0, 32'h0);
    commit(5'd5, 5'd3, 32'hDEAD_BEEF);
    #1;
    port("byp5", 0, 1'b0, 5'd0, 32'hDEAD_BEEF);
    tick();
    idle();
    #1;
    port("st5", 0, 1'b0, 5'd0, 32'hDEAD_BEEF);

    // older commit must not clear newer producer
    launch(5'd7, 5'd1);
    tick();
    launch(5'd7, 5'd4);
    tick();
    idle();
    commit(5'd7, 5'd1, 32'd9);
    rd(5'd7, 5'd5);
    port("old_c7", 0, 1'b1, 5'd4, 32'h0);
    tick();
    idle();
    #1;
    port("keep7", 0, 1'b1, 5'd4, 32'h0);

    // same-cycle launch and commit on r2
    launch(5'd2, 5'd6);
    tick();
    idle();
    launch(5'd2, 5'd6);
    commit(5'd2, 5'd6, 32'h55);
    rd(5'd2, 5'd7);
    port("lc2_byp", 0, 1'b0, 5'd0, 32'h55);
    tick();
    idle();
    #1;
    port("lc2", 0, 1'b1, 5'd6, 32'h0);

    // flush drops tags and a same-cycle launch
    launch(5'd3, 5'd2);
    tick();
    launch(5'd4, 5'd5);
    tick();
    idle();
    rd(5'd3, 5'd4);
    port("l3", 0, 1'b1, 5'd2, 32'h0);
    port("l4", 1, 1'b1, 5'd5, 32'h0);
    flush_in = 1'b1;
    launch(5'd8, 5'd7);
    tick();
    idle();
    #1;
    port("fl3", 0, 1'b0, 5'd0, 32'h0);
    port("fl4", 1, 1'b0, 5'd0, 32'h0);
    rd(5'd8, 5'd7);
    port("fl8", 0, 1'b0, 5'd0, 32'h0);
    port("fl7", 1, 1'b0, 5'd0, 32'd9);
    rd(5'd2, 5'd5);
    port("fl2", 0, 1'b0, 5'd0, 32'h55);
    port("fl5", 1, 1'b0, 5'd0, 32'hDEAD_BEEF);

    // register 0 ignores launch and commit
    launch(5'd0, 5'd1);
    commit(5'd0, 5'd1, 32'h123);
    rd(5'd0, 5'd0);
    port("r0_byp", 0, 1'b0, 5'd0, 32'h0);
    tick();
    idle();
    #1;
    port("r0", 0, 1'b0, 5'd0, 32'h0);

    // rdy_in low holds state
    rdy_in = 1'b0;
    launch(5'd9, 5'd3);
    commit(5'd5, 5'd0, 32'h77);
    tick();
    idle();
    rdy_in = 1'b1;
    rd(5'd9, 5'd5);
    port("hold9", 0, 1'b0, 5'd0, 32'h0);
    port("hold5", 1, 1'b0, 5'd0, 32'hDEAD_BEEF);

    // async reset mid-cycle with a busy register
    launch(5'd9, 5'd3);
    tick();
    idle();
    #1;
    port("pre_rst9", 0, 1'b1, 5'd3, 32'h0);
    #1;
    rst_in = 1'b0;
    #1;
    port("arst9", 0, 1'b0, 5'd0, 32'h0);
    port("arst5", 1, 1'b0, 5'd0, 32'h0);
    rst_in = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
